// File: rtl/io_mmio_ctrl_pkg.sv
// Shared IO map for the memory-mapped IO controller: register offsets,
// status bit positions and small decode helpers.
package io_mmio_ctrl_pkg;

    localparam int IO_OFFS_W = 8;

    localparam logic [IO_OFFS_W-1:0] IO_UART_CTRL = 8'h00;
    localparam logic [IO_OFFS_W-1:0] IO_UART_RX   = 8'h04;
    localparam logic [IO_OFFS_W-1:0] IO_UART_TX   = 8'h08;
    localparam logic [IO_OFFS_W-1:0] IO_CYC_CNT   = 8'h10;
    localparam logic [IO_OFFS_W-1:0] IO_INST_CNT  = 8'h14;
    localparam logic [IO_OFFS_W-1:0] IO_CNT_RST   = 8'h18;

    localparam int IO_ST_TX_READY = 0;
    localparam int IO_ST_RX_FULL  = 1;

    typedef enum logic [2:0] {
        IO_REG_STATUS,
        IO_REG_RX,
        IO_REG_TX,
        IO_REG_CYC,
        IO_REG_INST,
        IO_REG_CRST,
        IO_REG_NONE
    } io_reg_e;

    function automatic io_reg_e io_decode(input logic [IO_OFFS_W-1:0] offs);
        io_reg_e r;
        case (offs)
            IO_UART_CTRL: r = IO_REG_STATUS;
            IO_UART_RX:   r = IO_REG_RX;
            IO_UART_TX:   r = IO_REG_TX;
            IO_CYC_CNT:   r = IO_REG_CYC;
            IO_INST_CNT:  r = IO_REG_INST;
            IO_CNT_RST:   r = IO_REG_CRST;
            default:      r = IO_REG_NONE;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] io_status_word(input logic rx_full,
                                                   input logic tx_full);
        logic [31:0] w;
        w                 = '0;
        w[IO_ST_RX_FULL]  = rx_full;
        w[IO_ST_TX_READY] = ~tx_full;
        return w;
    endfunction

endpackage

// File: rtl/io_hold_reg.sv
// Single-entry valid/ready holding register. With PASS_ON_DRAIN set, a full
// entry accepts a new word in the same cycle it is drained.
module io_hold_reg #(
    parameter int WIDTH         = 8,
    parameter bit PASS_ON_DRAIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drain;
    logic             push;

    assign drain       = full_q & out_ready_i;
    assign in_ready_o  = ~full_q | (PASS_ON_DRAIN & out_ready_i);
    assign push        = in_valid_i & in_ready_o;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (push) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO controller: UART RX/TX holding registers, cycle and
// retired-instruction counters, one-cycle-latency registered load data.
module io_mmio_ctrl
    import io_mmio_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int UART_DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        io_addr,
    input  logic [31:0]        io_wdata,
    input  logic [3:0]         io_trans,
    input  logic               io_recv,
    output logic [31:0]        io_rdata,
    input  logic               inst_retire,
    output logic [UART_DW-1:0] uart_tx_data,
    output logic               uart_tx_valid,
    input  logic               uart_tx_ready,
    input  logic [UART_DW-1:0] uart_rx_data,
    input  logic               uart_rx_valid,
    output logic               uart_rx_ready
);

    io_reg_e                reg_sel;
    logic                   wr_tx;
    logic                   wr_cnt_rst;
    logic                   rx_pop;
    logic                   rx_full;
    logic [UART_DW-1:0]     rx_byte;
    logic                   tx_ready_in;
    logic [CNT_WIDTH-1:0]   cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0]   inst_q, inst_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            rd_mux;
    logic                   unused_bits;

    assign unused_bits = ^{io_addr[31:8], io_wdata[31:UART_DW], tx_ready_in};

    assign reg_sel    = io_decode(io_addr[7:0]);
    assign wr_tx      = io_trans[0] && (reg_sel == IO_REG_TX);
    assign wr_cnt_rst = (|io_trans) && (reg_sel == IO_REG_CRST);
    // Popping requires a full entry, so it can never collide with a capture.
    assign rx_pop     = io_recv && (reg_sel == IO_REG_RX) && rx_full;

    io_hold_reg #(
        .WIDTH         (UART_DW),
        .PASS_ON_DRAIN (1'b0)
    ) u_rx_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (uart_rx_valid),
        .in_data_i   (uart_rx_data),
        .in_ready_o  (uart_rx_ready),
        .out_valid_o (rx_full),
        .out_data_o  (rx_byte),
        .out_ready_i (rx_pop)
    );

    // A write landing on a full, stalled TX entry is dropped by in_ready_o.
    io_hold_reg #(
        .WIDTH         (UART_DW),
        .PASS_ON_DRAIN (1'b1)
    ) u_tx_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (wr_tx),
        .in_data_i   (io_wdata[UART_DW-1:0]),
        .in_ready_o  (tx_ready_in),
        .out_valid_o (uart_tx_valid),
        .out_data_o  (uart_tx_data),
        .out_ready_i (uart_tx_ready)
    );

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            IO_REG_STATUS: rd_mux = io_status_word(rx_full, uart_tx_valid);
            IO_REG_RX:     rd_mux = rx_full ? 32'(rx_byte) : 32'h0;
            IO_REG_CYC:    rd_mux = 32'(cyc_q);
            IO_REG_INST:   rd_mux = 32'(inst_q);
            default:       rd_mux = '0;
        endcase
    end

    always_comb begin
        cyc_d   = cyc_q + CNT_WIDTH'(1);
        inst_d  = inst_q + CNT_WIDTH'(inst_retire);
        rdata_d = rdata_q;
        if (wr_cnt_rst) begin
            cyc_d  = '0;
            inst_d = '0;
        end
        if (io_recv) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            inst_q  <= '0;
            rdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            rdata_q <= rdata_d;
        end
    end

    assign io_rdata = rdata_q;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl: directed scenarios then random
// traffic, all checked against a queue-based behavioural model.
module tb_io_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [3:0]  io_trans = '0;
    logic        io_recv = 1'b0;
    logic [31:0] io_rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [31:0] m_cyc = '0;
    logic [31:0] m_inst = '0;
    logic [31:0] m_rdata = '0;

    io_mmio_ctrl #(.CNT_WIDTH(32), .UART_DW(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_trans      (io_trans),
        .io_recv       (io_recv),
        .io_rdata      (io_rdata),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_cyc   = '0;
        m_inst  = '0;
        m_rdata = '0;
    endtask

    task automatic compare_outputs();
        chk("io_rdata", io_rdata, m_rdata);
        chk("tx_valid", {31'b0, uart_tx_valid}, {31'b0, txq.size() != 0});
        chk("rx_ready", {31'b0, uart_rx_ready}, {31'b0, rxq.size() == 0});
        if (txq.size() != 0) chk("tx_data", {24'b0, uart_tx_data}, {24'b0, txq[0]});
    endtask

    // One clock: predict from the inputs currently driven, step, then compare.
    task automatic tick();
        logic [7:0]  offs;
        logic [31:0] nrd;
        bit drain, pop, cap, txw, crst;
        offs  = io_addr[7:0];
        nrd   = m_rdata;
        if (io_recv) begin
            case (offs)
                8'h00:   nrd = {30'b0, rxq.size() != 0, txq.size() == 0};
                8'h04:   nrd = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
                8'h10:   nrd = m_cyc;
                8'h14:   nrd = m_inst;
                default: nrd = 32'h0;
            endcase
        end
        drain = (txq.size() != 0) && uart_tx_ready;
        pop   = io_recv && (offs == 8'h04) && (rxq.size() != 0);
        cap   = uart_rx_valid && (rxq.size() == 0);
        txw   = io_trans[0] && (offs == 8'h08);
        crst  = (io_trans != 4'b0) && (offs == 8'h18);
        @(posedge clk);
        #1;
        if (drain) void'(txq.pop_front());
        if (txw && txq.size() == 0) txq.push_back(io_wdata[7:0]);
        if (pop) void'(rxq.pop_front());
        if (cap) rxq.push_back(uart_rx_data);
        m_cyc   = crst ? 32'h0 : m_cyc + 32'h1;
        m_inst  = crst ? 32'h0 : m_inst + {31'b0, inst_retire};
        m_rdata = nrd;
        compare_outputs();
    endtask

    task automatic idle_bus();
        io_recv  = 1'b0;
        io_trans = 4'b0;
        io_addr  = '0;
        io_wdata = '0;
    endtask

    task automatic do_read(input logic [7:0] offs);
        io_addr  = {24'h100000, offs};
        io_recv  = 1'b1;
        io_trans = 4'b0;
        tick();
        idle_bus();
    endtask

    task automatic do_write(input logic [7:0] offs, input logic [31:0] d, input logic [3:0] be);
        io_addr  = {24'h100000, offs};
        io_wdata = d;
        io_trans = be;
        io_recv  = 1'b0;
        tick();
        idle_bus();
    endtask

    localparam int NOFFS = 9;
    logic [7:0] offs_tab [NOFFS] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C, 8'hFF};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_rdata", io_rdata, 32'h0);
        chk("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        chk("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);

        // Status after reset
        do_read(8'h00);
        chk("status_idle", io_rdata, 32'h1);

        // RX capture, status, pop, empty read
        uart_rx_data  = 8'h5A;
        uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
        chk("rx_ready_full", {31'b0, uart_rx_ready}, 32'h0);
        do_read(8'h00);
        chk("status_rx_full", io_rdata, 32'h3);
        do_read(8'h04);
        chk("rx_pop_data", io_rdata, 32'h5A);
        do_read(8'h04);
        chk("rx_empty_read", io_rdata, 32'h0);
        chk("rx_ready_again", {31'b0, uart_rx_ready}, 32'h1);

        // TX stall, drop, drain
        uart_tx_ready = 1'b0;
        do_write(8'h08, 32'hABCDEF41, 4'b0001);
        chk("tx_valid_set", {31'b0, uart_tx_valid}, 32'h1);
        chk("tx_data_41", {24'b0, uart_tx_data}, 32'h41);
        do_write(8'h08, 32'h00000042, 4'b1111);
        chk("tx_drop_keep", {24'b0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        chk("tx_drained", {31'b0, uart_tx_valid}, 32'h0);

        // Write while draining replaces the entry
        do_write(8'h08, 32'h10, 4'b0001);
        uart_tx_ready = 1'b1;
        do_write(8'h08, 32'h11, 4'b0001);
        chk("tx_wod_valid", {31'b0, uart_tx_valid}, 32'h1);
        chk("tx_wod_data", {24'b0, uart_tx_data}, 32'h11);
        tick();
        uart_tx_ready = 1'b0;

        // Upper byte enable alone does not write TX
        do_write(8'h08, 32'h77, 4'b1110);
        chk("tx_lane0_only", {31'b0, uart_tx_valid}, 32'h0);

        // Counters with alternating retire, then counter reset
        for (int i = 0; i < 100; i++) begin
            inst_retire = i[0];
            tick();
        end
        inst_retire = 1'b0;
        do_read(8'h10);
        do_read(8'h14);
        do_write(8'h18, 32'h0, 4'b0100);
        do_read(8'h10);
        chk("cyc_after_rst", io_rdata, 32'h0);
        do_read(8'h14);
        chk("inst_after_rst", io_rdata, 32'h0);

        // Reset write coinciding with a retire still reads zero
        inst_retire = 1'b1;
        do_write(8'h18, 32'h0, 4'b0001);
        inst_retire = 1'b0;
        do_read(8'h14);
        chk("inst_rst_prio", io_rdata, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            int kind;
            kind          = int'($urandom_range(0, 3));
            idle_bus();
            io_addr       = {$urandom_range(0, 32'hFFFFFF), offs_tab[$urandom_range(0, NOFFS - 1)]};
            if (kind == 1) io_recv = 1'b1;
            if (kind == 2) begin
                io_wdata = $urandom;
                io_trans = 4'($urandom_range(0, 15));
            end
            uart_tx_ready = ($urandom_range(0, 2) == 0);
            uart_rx_valid = ($urandom_range(0, 1) == 0);
            uart_rx_data  = 8'($urandom);
            inst_retire   = ($urandom_range(0, 1) == 0);
            tick();
        end
        idle_bus();
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        inst_retire   = 1'b0;

        // Async reset while TX holds a byte
        do_write(8'h08, 32'h99, 4'b0001);
        chk("tx_full_pre_rst", {31'b0, uart_tx_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("tx_valid_async_drop", {31'b0, uart_tx_valid}, 32'h0);
        chk("rdata_async_clear", io_rdata, 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_read(8'h10);
        chk("cyc_post_rst", io_rdata, 32'h0);
        do_read(8'h14);
        chk("inst_post_rst", io_rdata, 32'h0);
        do_read(8'h00);
        chk("status_post_rst", io_rdata, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/io_mmio_ctrl.md
Name: io_mmio_ctrl

Overview:
- Memory-mapped IO controller behind the pipeline's memory stage.
- Consumes the per-byte IO write strobes and IO load strobe produced by the memory-control decode for addresses with A[31:28]==4'b1000.
- Buffers UART traffic in both directions and provides cycle and retired-instruction counters.
- Returns load data with one-cycle latency, matching data-memory read timing.

Parameters:
- CNT_WIDTH, 32, width of the cycle and instruction counters (wrap modulo 2^CNT_WIDTH).
- UART_DW, 8, UART data byte width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- io_addr  in  32  load/store address; only io_addr[7:0] is decoded here
- io_wdata  in  32  store data, already lane-aligned
- io_trans  in  4  per-byte IO write enable, already hazard-gated upstream
- io_recv  in  1  IO load strobe
- io_rdata  out  32  load data, valid the cycle after io_recv
- inst_retire  in  1  one pulse per retired instruction
- uart_tx_data  out  UART_DW  byte to transmitter
- uart_tx_valid  out  1  transmit byte available
- uart_tx_ready  in  1  transmitter accepts byte
- uart_rx_data  in  UART_DW  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ready  out  1  controller can accept a byte

Behaviour:
- Reset (async, rst_n=0):
  - rx_full=0, tx_full=0, both counters=0, io_rdata=0, uart_tx_valid=0.
  - uart_rx_ready = ~rx_full, so it reads 1 after reset.
  - Buffered bytes are lost on reset at any time; uart_tx_valid drops immediately.
- Address map (offset = io_addr[7:0]):
  - 0x00 RO status: {30'b0, rx_full, ~tx_full}.
  - 0x04 RO rx data: {24'b0, rx_byte}. A read with rx_full=1 pops (rx_full→0 next cycle). A read with rx_full=0 returns 0 and changes nothing.
  - 0x08 WO tx data: write when io_trans[0]=1; takes io_wdata[7:0]. Upper byte enables are ignored.
  - 0x10 RO cycle counter.
  - 0x14 RO instruction counter.
  - 0x18 WO counter reset: any io_trans bit set clears both counters.
  - Other offsets: reads return 0; writes are ignored.
  - Writes to RO offsets and reads of WO offsets: write ignored, read returns 0.
- RX holding register (1 entry):
  - uart_rx_ready = ~rx_full.
  - Capture on uart_rx_valid & uart_rx_ready.
  - Capture and pop cannot coincide: capture needs empty, pop needs full.
- TX holding register (1 entry):
  - uart_tx_valid = tx_full; uart_tx_data = tx_byte.
  - Drain on uart_tx_valid & uart_tx_ready.
  - Write when tx_full=0: accepted; tx_full=1 next cycle.
  - Write when tx_full=1 and draining in the same cycle: accepted; tx_full stays 1 with the new byte.
  - Write when tx_full=1 and not draining: dropped silently. Software polls status bit0.
- Counters:
  - Cycle counter increments every cycle.
  - Instruction counter increments when inst_retire=1.
  - Both wrap at all-ones → 0.
  - A reset write has priority over increment: both read 0 the following cycle, not 1.
- Read path:
  - io_rdata is registered and reflects state sampled in the io_recv cycle, before that cycle's updates.
  - Holds its value until the next io_recv.
  - io_recv and io_trans asserted together is illegal upstream (load and store are exclusive); the write takes effect and io_rdata is unspecified.

Decomposition:
- Shared header IoMap.vh (alongside Opcode.vh): offset constants IO_UART_CTRL, IO_UART_RX, IO_UART_TX, IO_CYC_CNT, IO_INST_CNT, IO_CNT_RST, and status bit indices.
- One sub-module, io_hold_reg: single-entry valid/ready holding register parameterised by width. Instantiated for RX and TX; the TX instance needs the write-while-drain rule above.

Test Plan:
- Reset release, then read 0x00 → io_rdata=32'h1 next cycle (rx empty, tx ready); uart_rx_ready=1, uart_tx_valid=0.
- uart_rx_valid with byte 8'h5A → uart_rx_ready=0; status reads 32'h3; read 0x04 → 32'h5A; next read 0x04 → 0; uart_rx_ready=1 again.
- Write 0x08 data 32'h41 with uart_tx_ready=0 → tx_valid=1, tx_data=8'h41. Second write 8'h42 while stalled → dropped. Raise ready one cycle → 8'h41 sent, tx_valid=0.
- tx_full with byte 8'h10; write 8'h11 in the same cycle uart_tx_ready=1 → 8'h10 drains; tx_valid stays 1 with 8'h11.
- Run 100 cycles with inst_retire on alternate cycles; read 0x10 and 0x14 → consistent values. Write 0x18 → both read 0 the cycle after.
- Assert rst_n=0 mid-transfer with tx_full=1 → uart_tx_valid=0 immediately; counters 0 after release.
